// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_driver
// Purpose  : Converts a 16-bit unsigned value to 4-digit BCD with a sequential
//            double-dabble engine (one bit per clock) and drives a multiplexed,
//            active-low 4-digit seven-segment display from the latched result.
//            Values above 9999 latch an overflow flag and show dashes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1  core clock
//   rst            in   1  asynchronous active-high reset
//   value_in       in  16  unsigned binary value to display
//   value_valid    in   1  one-cycle strobe, sample value_in
//   busy           out  1  conversion in progress
//   bcd_out        out 16  latched BCD result, thousands digit in [15:12]
//   ovf_out        out  1  latched value exceeded 9999
//   seven_seg_out  out  7  active-low segments, order gfedcba
//   Anode_Activate out  4  active-low digit enables, bit 3 = leftmost
// ============================================================================
module seg_display_driver #(
    parameter int REFRESH_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    output logic        busy,
    output logic [15:0] bcd_out,
    output logic        ovf_out,
    output logic [6:0]  seven_seg_out,
    output logic [3:0]  Anode_Activate
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;

    logic [REFRESH_BITS-1:0] refresh_q;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  anode_q, anode_d;

    // Add 3 to every BCD nibble >= 5 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] a);
        logic [19:0] r;
        r = a;
        for (int i = 0; i < 5; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [35:0] w_shifted;
    logic [15:0] w_next_val;

    assign w_shifted  = {dabble_adjust(acc_q), bin_q} << 1;
    // A strobe arriving on the DONE edge is newer than anything pending.
    assign w_next_val = value_valid ? value_in : pend_q;

    // ------------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (value_valid) begin
                    bin_d   = value_in;
                    acc_d   = 20'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (value_valid) begin
                    pend_d     = value_in;
                    pend_vld_d = 1'b1;
                end
                acc_d = w_shifted[35:16];
                bin_d = w_shifted[15:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d = acc_q[15:0];
                ovf_d = (acc_q[19:16] != 4'd0);
                if (value_valid || pend_vld_q) begin
                    // Back-to-back conversion: busy stays asserted.
                    bin_d      = w_next_val;
                    acc_d      = 20'd0;
                    cnt_d      = 4'd0;
                    pend_vld_d = 1'b0;
                    state_d    = S_SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bin_q      <= 16'd0;
            acc_q      <= 20'd0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            pend_q     <= 16'd0;
            pend_vld_q <= 1'b0;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Display multiplexer: driven only from the latched result, so nothing
    // changes on the digits while a conversion is running.
    // ------------------------------------------------------------------------
    logic [1:0] w_sel;
    logic       w_blank3, w_blank2, w_blank1;

    assign w_sel    = refresh_q[REFRESH_BITS-1 -: 2];
    assign w_blank3 = (bcd_q[15:12] == 4'd0);
    assign w_blank2 = w_blank3 && (bcd_q[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (bcd_q[7:4] == 4'd0);

    always_comb begin
        anode_d = 4'b1111;
        seg_d   = SEG_BLANK;
        case (w_sel)
            2'b00: begin
                anode_d = 4'b0111;
                seg_d   = w_blank3 ? SEG_BLANK : seg_code(bcd_q[15:12]);
            end
            2'b01: begin
                anode_d = 4'b1011;
                seg_d   = w_blank2 ? SEG_BLANK : seg_code(bcd_q[11:8]);
            end
            2'b10: begin
                anode_d = 4'b1101;
                seg_d   = w_blank1 ? SEG_BLANK : seg_code(bcd_q[7:4]);
            end
            default: begin
                anode_d = 4'b1110;
                seg_d   = seg_code(bcd_q[3:0]);
            end
        endcase
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            anode_q   <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            refresh_q <= refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign busy           = busy_q;
    assign bcd_out        = bcd_q;
    assign ovf_out        = ovf_q;
    assign seven_seg_out  = seg_q;
    assign Anode_Activate = anode_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_driver
// Purpose  : Self-checking bench for seg_display_driver with REFRESH_BITS=4
//            (one digit every 4 cycles, full scan every 16 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_driver;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        value_valid;
    logic        busy;
    logic [15:0] bcd_out;
    logic        ovf_out;
    logic [6:0]  seven_seg_out;
    logic [3:0]  Anode_Activate;

    int checks = 0;
    int errors = 0;

    logic [15:0] seen[$];

    seg_display_driver #(.REFRESH_BITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .value_in       (value_in),
        .value_valid    (value_valid),
        .busy           (busy),
        .bcd_out        (bcd_out),
        .ovf_out        (ovf_out),
        .seven_seg_out  (seven_seg_out),
        .Anode_Activate (Anode_Activate)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     val;
        logic [15:0]     bcd;
        logic            ovf;
        logic [3:0][6:0] segs;   // [3] = thousands (leftmost)
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe a value; returns at the falling edge right after the capture edge.
    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        value_in    = v;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    // Counts falling-edge samples with busy high; 17 for a single conversion.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy still high expected low within 100 cycles");
        end
    endtask

    // Sample one full scan and compare each digit against its expected code.
    task automatic check_display(input logic [3:0][6:0] exp);
        int idx;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx = -1;
            case (Anode_Activate)
                4'b0111: idx = 3;
                4'b1011: idx = 2;
                4'b1101: idx = 1;
                4'b1110: idx = 0;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                chk("anode_pattern", {28'd0, Anode_Activate}, 32'h7);
            end else begin
                chk($sformatf("seg_digit%0d", idx), {25'd0, seven_seg_out}, {25'd0, exp[idx]});
            end
        end
    endtask

    // Start v0, then optionally strobe v1/v2 at sample index n1/n2 (index 1 is
    // the falling edge after the capture edge E0). Records every bcd_out change.
    task automatic run_seq(input logic [15:0] v0, input int n1, input logic [15:0] v1,
                           input int n2, input logic [15:0] v2, output int nb);
        logic [15:0] prev;
        int n;
        prev = bcd_out;
        seen.delete();
        nb = 0;
        @(negedge clk);
        value_in    = v0;
        value_valid = 1'b1;
        @(negedge clk);
        n = 1;
        while (busy && n < 200) begin
            nb++;
            if (n == n1) begin
                value_in = v1; value_valid = 1'b1;
            end else if (n == n2) begin
                value_in = v2; value_valid = 1'b1;
            end else begin
                value_valid = 1'b0;
            end
            @(negedge clk);
            n++;
            if (bcd_out !== prev) begin
                seen.push_back(bcd_out);
                prev = bcd_out;
            end
        end
        value_valid = 1'b0;
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL seq_timeout: got busy still high expected low within 200 cycles");
        end
    endtask

    initial begin
        int nb;

        vecs[0] = '{16'd1234,  16'h1234, 1'b0, {S1, S2, S3, S4}};
        vecs[1] = '{16'd7,     16'h0007, 1'b0, {B,  B,  B,  S7}};
        vecs[2] = '{16'd10000, 16'h0000, 1'b1, {DS, DS, DS, DS}};
        vecs[3] = '{16'd9999,  16'h9999, 1'b0, {S9, S9, S9, S9}};
        vecs[4] = '{16'd0,     16'h0000, 1'b0, {B,  B,  B,  S0}};
        vecs[5] = '{16'd305,   16'h0305, 1'b0, {B,  S3, S0, S5}};
        vecs[6] = '{16'd65535, 16'h5535, 1'b1, {DS, DS, DS, DS}};
        vecs[7] = '{16'd1000,  16'h1000, 1'b0, {S1, S0, S0, S0}};
        vecs[8] = '{16'd80,    16'h0080, 1'b0, {B,  B,  S8, S0}};

        rst         = 1'b1;
        value_in    = 16'd0;
        value_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_bcd",   {16'd0, bcd_out}, 32'h0);
        chk("rst_ovf",   {31'd0, ovf_out}, 32'd0);
        chk("rst_anode", {28'd0, Anode_Activate}, 32'hF);
        chk("rst_seg",   {25'd0, seven_seg_out}, {25'd0, B});

        rst = 1'b0;
        @(negedge clk);
        // First edge after release: refresh was 0, so thousands digit, blank.
        chk("first_anode", {28'd0, Anode_Activate}, 32'h7);
        chk("first_seg",   {25'd0, seven_seg_out}, {25'd0, B});
        check_display({B, B, B, S0});

        for (int i = 0; i < 9; i++) begin
            strobe(vecs[i].val);
            wait_done(nb);
            chk($sformatf("latency_%0d", vecs[i].val), nb, 32'd17);
            chk($sformatf("bcd_%0d", vecs[i].val), {16'd0, bcd_out}, {16'd0, vecs[i].bcd});
            chk($sformatf("ovf_%0d", vecs[i].val), {31'd0, ovf_out}, {31'd0, vecs[i].ovf});
            check_display(vecs[i].segs);
        end

        // 42, then 99 and 55 while busy: only 55 survives in pending.
        // Busy spans edges E0..E34 and is sampled after each of E0..E33.
        run_seq(16'd42, 2, 16'd99, 3, 16'd55, nb);
        chk("seq_busy_cycles", nb, 32'd34);
        chk("seq_changes", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            chk("seq_first",  {16'd0, seen[0]}, 32'h0042);
            chk("seq_second", {16'd0, seen[1]}, 32'h0055);
        end
        check_display({B, B, S5, S5});

        // Strobe coincident with the DONE edge of 8 starts the next conversion.
        run_seq(16'd8, 17, 16'd3, 0, 16'd0, nb);
        chk("done_busy_cycles", nb, 32'd34);
        chk("done_changes", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            chk("done_first",  {16'd0, seen[0]}, 32'h0008);
            chk("done_second", {16'd0, seen[1]}, 32'h0003);
        end

        // Reset in the middle of converting 1234.
        strobe(16'd1234);
        repeat (7) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_bcd",   {16'd0, bcd_out}, 32'h0);
        chk("abort_ovf",   {31'd0, ovf_out}, 32'd0);
        chk("abort_anode", {28'd0, Anode_Activate}, 32'hF);
        chk("abort_seg",   {25'd0, seven_seg_out}, {25'd0, B});
        @(negedge clk);
        rst = 1'b0;
        strobe(16'd5);
        wait_done(nb);
        chk("post_abort_latency", nb, 32'd17);
        chk("post_abort_bcd", {16'd0, bcd_out}, 32'h0005);
        check_display({B, B, B, S5});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
